// File: rtl/eu_ring_pkg.sv
// Shared constants, state encoding and helpers for the ring node.
package eu_ring_pkg;

  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_SEND  = 8'h11;
  localparam logic [7:0] CMD_CLR   = 8'h21;
  localparam logic [7:0] BC_ID     = 8'hFF;
  localparam logic [7:0] REPLY_HDR = 8'hAA;

  typedef enum logic [2:0] {
    RECV,
    DECODE,
    FWD,
    EXEC,
    REPLY
  } state_e;

  // Reply packet: header, node ID, one beat per register, checksum.
  function automatic int reply_len(input int reg_n);
    return reg_n + 3;
  endfunction

endpackage

// File: rtl/eu_pkt_buf.sv
// Store-and-forward packet buffer: write side captures one packet, tracks
// overflow and length; read side exposes a forward port, the two header
// beats and the register payload window.
module eu_pkt_buf #(
  parameter  int AXIS_DIN_W = 8,
  parameter  int BUF_S      = 64,
  parameter  int PAY_N      = 16,
  localparam int AW         = $clog2(BUF_S),
  localparam int PW         = $clog2(BUF_S + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             wr_en_i,
  input  logic                             wr_last_i,
  input  logic [AXIS_DIN_W-1:0]            wr_data_i,
  input  logic [AW-1:0]                    rd_addr_i,
  output logic [AXIS_DIN_W-1:0]            rd_data_o,
  output logic [AXIS_DIN_W-1:0]            hdr0_o,
  output logic [AXIS_DIN_W-1:0]            hdr1_o,
  output logic [PAY_N-1:0][AXIS_DIN_W-1:0] pay_o,
  output logic [PW-1:0]                    len_o,
  output logic                             ovf_o
);

  logic [AXIS_DIN_W-1:0] mem [BUF_S];
  logic [PW-1:0]         wr_ptr_q;
  logic                  ovf_run_q;
  logic                  full;

  // Pointer parks at BUF_S once the buffer is full; further beats are lost.
  assign full = (wr_ptr_q == PW'(BUF_S));

  // Beat storage; contents are only meaningful below the captured length.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !full) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Write pointer, running overflow flag and end-of-packet length capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      ovf_run_q <= 1'b0;
      len_o     <= '0;
      ovf_o     <= 1'b0;
    end else if (wr_en_i) begin
      if (wr_last_i) begin
        wr_ptr_q  <= '0;
        ovf_run_q <= 1'b0;
        ovf_o     <= ovf_run_q | full;
        len_o     <= full ? PW'(BUF_S) : wr_ptr_q + PW'(1);
      end else if (full) begin
        ovf_run_q <= 1'b1;
      end else begin
        wr_ptr_q  <= wr_ptr_q + PW'(1);
      end
    end
  end

  assign rd_data_o = mem[rd_addr_i];
  assign hdr0_o    = mem[0];
  assign hdr1_o    = mem[1];

  for (genvar i = 0; i < PAY_N; i++) begin : g_pay
    assign pay_o[i] = mem[i + 2];
  end

endmodule

// File: rtl/eu_ring_node.sv
// Performance-monitor ring node: buffers a packet, forwards foreign or
// broadcast traffic, executes local/broadcast commands and emits replies.
module eu_ring_node
  import eu_ring_pkg::*;
#(
  parameter int         AXIS_DIN_W = 8,
  parameter logic [7:0] ID         = 8'h01,
  parameter int         BUF_S      = 64,
  parameter int         REG_N      = 16,
  parameter int         CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic                  s_axis_tlast_i,
  input  logic [AXIS_DIN_W-1:0] s_axis_tdata_i,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  m_axis_tlast_o,
  output logic [AXIS_DIN_W-1:0] m_axis_tdata_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic [CNT_W-1:0]      fwd_cnt_o
);

  localparam int W    = AXIS_DIN_W;
  localparam int AW   = $clog2(BUF_S);
  localparam int PW   = $clog2(BUF_S + 1);
  localparam int RLEN = reply_len(REG_N);
  localparam int RW   = $clog2(RLEN);

  state_e                  state_q, state_d;
  logic                    exec_pend_q, exec_pend_d;
  logic [PW-1:0]           rd_ptr_q;
  logic [RW-1:0]           rp_idx_q;
  logic [REG_N-1:0][W-1:0] regs_q;
  logic                    drop_inc, fwd_inc;
  logic                    out_hs;

  logic [W-1:0]            rd_data, hdr0, hdr1;
  logic [REG_N-1:0][W-1:0] pay;
  logic [PW-1:0]           len;
  logic                    ovf;
  logic [W-1:0]            csum, rbeat;

  eu_pkt_buf #(
    .AXIS_DIN_W (W),
    .BUF_S      (BUF_S),
    .PAY_N      (REG_N)
  ) u_buf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (s_axis_tvalid_i && (state_q == RECV)),
    .wr_last_i (s_axis_tlast_i),
    .wr_data_i (s_axis_tdata_i),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data),
    .hdr0_o    (hdr0),
    .hdr1_o    (hdr1),
    .pay_o     (pay),
    .len_o     (len),
    .ovf_o     (ovf)
  );

  assign out_hs = m_axis_tvalid_o && m_axis_tready_i;

  // Reply beat selection; checksum covers header, ID and every register.
  always_comb begin
    csum = W'(REPLY_HDR) ^ W'(ID);
    for (int i = 0; i < REG_N; i++) csum = csum ^ regs_q[i];
    rbeat = '0;
    if (rp_idx_q == RW'(0))           rbeat = W'(REPLY_HDR);
    else if (rp_idx_q == RW'(1))      rbeat = W'(ID);
    else if (rp_idx_q == RW'(RLEN-1)) rbeat = csum;
    for (int i = 0; i < REG_N; i++) begin
      if (rp_idx_q == RW'(i + 2)) rbeat = regs_q[i];
    end
  end

  // Next-state, stream outputs and counter increments.
  always_comb begin
    state_d         = state_q;
    exec_pend_d     = exec_pend_q;
    s_axis_tready_o = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tdata_o  = '0;
    drop_inc        = 1'b0;
    fwd_inc         = 1'b0;
    case (state_q)
      RECV: begin
        s_axis_tready_o = 1'b1;
        if (s_axis_tvalid_i && s_axis_tlast_i) state_d = DECODE;
      end
      DECODE: begin
        if (ovf || len < PW'(2)) begin
          drop_inc = 1'b1;
          state_d  = RECV;
        end else if (hdr0[7:0] == ID) begin
          state_d = EXEC;
        end else if (hdr0[7:0] == BC_ID) begin
          exec_pend_d = 1'b1;
          state_d     = FWD;
        end else begin
          state_d = FWD;
        end
      end
      FWD: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = rd_data;
        m_axis_tlast_o  = (rd_ptr_q == len - PW'(1));
        if (m_axis_tready_i && m_axis_tlast_o) begin
          fwd_inc     = 1'b1;
          exec_pend_d = 1'b0;
          state_d     = exec_pend_q ? EXEC : RECV;
        end
      end
      EXEC: begin
        case (hdr1[7:0])
          CMD_WR, CMD_CLR: state_d = RECV;
          CMD_SEND:        state_d = REPLY;
          default: begin
            drop_inc = 1'b1;
            state_d  = RECV;
          end
        endcase
      end
      REPLY: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = rbeat;
        m_axis_tlast_o  = (rp_idx_q == RW'(RLEN-1));
        if (m_axis_tready_i && m_axis_tlast_o) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  // State, broadcast-pending flag and output-side beat pointers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= RECV;
      exec_pend_q <= 1'b0;
      rd_ptr_q    <= '0;
      rp_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      exec_pend_q <= exec_pend_d;
      if (state_q == FWD && out_hs)
        rd_ptr_q <= m_axis_tlast_o ? '0 : rd_ptr_q + PW'(1);
      if (state_q == REPLY && out_hs)
        rp_idx_q <= m_axis_tlast_o ? '0 : rp_idx_q + RW'(1);
    end
  end

  // Register file: write copies only the payload beats actually present.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q <= '0;
    end else if (state_q == EXEC) begin
      if (hdr1[7:0] == CMD_WR) begin
        for (int i = 0; i < REG_N; i++) begin
          if (PW'(i) < len - PW'(2)) regs_q[i] <= pay[i];
        end
      end else if (hdr1[7:0] == CMD_CLR) begin
        regs_q <= '0;
      end
    end
  end

  // Saturating drop/forward statistics.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_cnt_o <= '0;
      fwd_cnt_o  <= '0;
    end else begin
      if (drop_inc && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      if (fwd_inc && fwd_cnt_o != '1)   fwd_cnt_o  <= fwd_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eu_ring_node.sv
// Directed bench for eu_ring_node: packet table plus corner sequences.
module tb_eu_ring_node;

  localparam int W     = 8;
  localparam int BUF_S = 64;
  localparam int REG_N = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_last;
  logic [W-1:0]     s_data;
  logic             m_valid, m_ready, m_last;
  logic [W-1:0]     m_data;
  logic [CNT_W-1:0] drop_cnt, fwd_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eu_ring_node #(
    .AXIS_DIN_W (W),
    .ID         (8'h01),
    .BUF_S      (BUF_S),
    .REG_N      (REG_N),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .s_axis_tvalid_i (s_valid),
    .s_axis_tready_o (s_ready),
    .s_axis_tlast_i  (s_last),
    .s_axis_tdata_i  (s_data),
    .m_axis_tvalid_o (m_valid),
    .m_axis_tready_i (m_ready),
    .m_axis_tlast_o  (m_last),
    .m_axis_tdata_o  (m_data),
    .drop_cnt_o      (drop_cnt),
    .fwd_cnt_o       (fwd_cnt)
  );

  typedef struct {
    int                n_in;
    logic [0:7][7:0]   din;
    int                n_out;
    int                brk;   // tlast also expected on beat brk-1 (0: none)
    logic [0:23][7:0]  dout;
    bit                rnd;
    bit                lat;
    int                fwd;
    int                drop;
  } vec_t;

  vec_t         vq[$];
  logic [W-1:0] pb [0:127];
  logic [W-1:0] got_d [0:127];
  logic         got_l [0:127];
  int           got_n, first_cyc, tl_cyc, mid_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int ni, input logic [0:7][7:0] di, input int no, input int bk,
                     input logic [0:23][7:0] dq, input bit rn, input bit lt,
                     input int f, input int d);
    vec_t t;
    t.n_in = ni; t.din = di; t.n_out = no; t.brk = bk; t.dout = dq;
    t.rnd = rn; t.lat = lt; t.fwd = f; t.drop = d;
    vq.push_back(t);
  endtask

  // Drive pb[0..n-1] as one packet, waiting for tready on each beat.
  task automatic send(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = pb[i]; s_last = (i == n - 1);
      @(negedge clk);
      t = 0;
      while (!s_ready && t < 400) begin
        if (i > 0) mid_drop++;
        @(negedge clk);
        t++;
      end
      if (!s_ready) chk("send_ready_timeout", {31'b0, s_ready}, 1);
      tl_cyc = cyc;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Collect n_exp output beats, checking hold-stability while stalled,
  // then watch a short window for unexpected extra output.
  task automatic recv(input int n_exp, input bit rnd);
    int t, extra;
    logic [W-1:0] hd;
    logic hl;
    bit held;
    got_n = 0; first_cyc = -1; held = 0; t = 0; hd = '0; hl = 1'b0;
    while (got_n < n_exp && t < 2000) begin
      m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (held) begin
        chk("stall_valid", {31'b0, m_valid}, 1);
        chk("stall_data", {24'b0, m_data}, {24'b0, hd});
        chk("stall_last", {31'b0, m_last}, {31'b0, hl});
      end
      held = 0;
      if (m_valid && m_ready) begin
        got_d[got_n] = m_data; got_l[got_n] = m_last; got_n++;
      end else if (m_valid) begin
        held = 1; hd = m_data; hl = m_last;
      end
      @(posedge clk); #1;
      t++;
    end
    m_ready = 1'b1;
    if (got_n != n_exp) chk("recv_beats", got_n, n_exp);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_valid) extra++;
      @(posedge clk); #1;
    end
    chk("no_extra_output", extra, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1; mid_drop = 0;
    tl_cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_tready", {31'b0, s_ready}, 1);
    chk("rst_tvalid", {31'b0, m_valid}, 0);
    chk("rst_tlast",  {31'b0, m_last}, 0);
    chk("rst_tdata",  {24'b0, m_data}, 0);
    chk("rst_drop",   {16'b0, drop_cnt}, 0);
    chk("rst_fwd",    {16'b0, fwd_cnt}, 0);
    @(posedge clk); #1;

    // foreign forward, first valid 2 cycles after tlast
    add(4, {8'h02,8'h01,8'h33,8'h44,32'h0}, 4, 0, {8'h02,8'h01,8'h33,8'h44,160'h0}, 0, 1, 1, 0);
    // local write of three registers
    add(5, {8'h01,8'h01,8'hAA,8'hBB,8'hCC,24'h0}, 0, 0, 192'h0, 0, 0, 1, 0);
    // local send: AA,01,AA,BB,CC,13x00, checksum 76
    add(2, {8'h01,8'h11,48'h0}, 19, 0,
        {8'hAA,8'h01,8'hAA,8'hBB,8'hCC,104'h0,8'h76,40'h0}, 0, 0, 1, 0);
    // broadcast clear: forwarded unchanged, then registers cleared
    add(2, {8'hFF,8'h21,48'h0}, 2, 0, {8'hFF,8'h21,176'h0}, 0, 0, 2, 0);
    // send after clear: all registers zero, checksum AA^01
    add(2, {8'h01,8'h11,48'h0}, 19, 0, {8'hAA,8'h01,128'h0,8'hAB,40'h0}, 0, 0, 2, 0);
    // runt
    add(1, {8'h01,56'h0}, 0, 0, 192'h0, 0, 0, 2, 1);
    // unknown local command
    add(2, {8'h01,8'h55,48'h0}, 0, 0, 192'h0, 0, 0, 2, 2);
    // broadcast write of reg0
    add(3, {8'hFF,8'h01,8'h12,40'h0}, 3, 0, {8'hFF,8'h01,8'h12,168'h0}, 0, 0, 3, 2);
    // broadcast send: forwarded then reply
    add(2, {8'hFF,8'h11,48'h0}, 21, 2,
        {8'hFF,8'h11,8'hAA,8'h01,8'h12,120'h0,8'hB9,24'h0}, 0, 0, 4, 2);
    // local write, then reply under random backpressure (checksum 3D)
    add(5, {8'h01,8'h01,8'h5A,8'hC3,8'h0F,24'h0}, 0, 0, 192'h0, 0, 0, 4, 2);
    add(2, {8'h01,8'h11,48'h0}, 19, 0,
        {8'hAA,8'h01,8'h5A,8'hC3,8'h0F,104'h0,8'h3D,40'h0}, 1, 0, 4, 2);

    for (int v = 0; v < vq.size(); v++) begin
      for (int i = 0; i < vq[v].n_in; i++) pb[i] = vq[v].din[i];
      send(vq[v].n_in);
      recv(vq[v].n_out, vq[v].rnd);
      for (int j = 0; j < got_n; j++) begin
        chk($sformatf("v%0d_data%0d", v, j), {24'b0, got_d[j]}, {24'b0, vq[v].dout[j]});
        chk($sformatf("v%0d_last%0d", v, j), {31'b0, got_l[j]},
            {31'b0, (j == vq[v].n_out - 1) || (j == vq[v].brk - 1)});
      end
      if (vq[v].lat) chk("latency", first_cyc - tl_cyc, 2);
      chk($sformatf("v%0d_fwd", v),  {16'b0, fwd_cnt},  vq[v].fwd);
      chk($sformatf("v%0d_drop", v), {16'b0, drop_cnt}, vq[v].drop);
    end

    // exactly BUF_S beats: fits, forwarded whole
    for (int i = 0; i < 128; i++) pb[i] = 8'(i + 8'h40);
    pb[0] = 8'h02;
    send(BUF_S);
    recv(BUF_S, 0);
    for (int j = 0; j < got_n; j++) begin
      chk($sformatf("full_data%0d", j), {24'b0, got_d[j]}, {24'b0, pb[j]});
      chk($sformatf("full_last%0d", j), {31'b0, got_l[j]}, {31'b0, j == BUF_S - 1});
    end
    chk("full_fwd", {16'b0, fwd_cnt}, 5);

    // BUF_S+1 and BUF_S+5 beats: oversize, dropped, tready held high
    mid_drop = 0;
    send(BUF_S + 1);
    recv(0, 0);
    chk("ovf1_drop", {16'b0, drop_cnt}, 3);
    send(BUF_S + 5);
    recv(0, 0);
    chk("ovf5_drop", {16'b0, drop_cnt}, 4);
    chk("ovf_fwd", {16'b0, fwd_cnt}, 5);
    chk("tready_mid_packet", mid_drop, 0);

    // reset in the middle of a stalled forward
    pb[0] = 8'h03; pb[1] = 8'hAA; pb[2] = 8'hBB; pb[3] = 8'hCC; pb[4] = 8'hDD;
    m_ready = 1'b0;
    send(5);
    t = 0;
    @(negedge clk);
    while (!m_valid && t < 50) begin @(negedge clk); t++; end
    chk("pre_rst_valid", {31'b0, m_valid}, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'b0, m_valid}, 0);
    chk("post_rst_ready", {31'b0, s_ready}, 1);
    chk("post_rst_drop",  {16'b0, drop_cnt}, 0);
    chk("post_rst_fwd",   {16'b0, fwd_cnt}, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    pb[0] = 8'h04; pb[1] = 8'h05;
    send(2);
    recv(2, 0);
    if (got_n == 2) begin
      chk("after_rst_d0", {24'b0, got_d[0]}, 32'h04);
      chk("after_rst_d1", {24'b0, got_d[1]}, 32'h05);
      chk("after_rst_l1", {31'b0, got_l[1]}, 1);
    end
    chk("after_rst_fwd", {16'b0, fwd_cnt}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eu_ring_node.md
Name: eu_ring_node

Overview:
- Next-generation execution-unit node for the performance-monitor ring.
- Receives AXI-Stream command packets into a store-and-forward buffer and decodes the destination ID (beat 0) and command (beat 1).
- Forwards foreign packets unchanged, executes packets addressed to itself or to broadcast against a local register file, and emits reply packets.
- Generalised in data width, buffer depth and register count; adds a clear command, drop handling for runt/oversize packets, and drop/forward statistics.

Parameters:
- AXIS_DIN_W, 8, stream data width; must be >= 8. ID and command are compared on bits [7:0].
- ID, 8'h01, node identifier; 8'hFF is reserved for broadcast.
- BUF_S, 64, packet buffer depth in beats; must be >= REG_N+3.
- REG_N, 16, number of AXIS_DIN_W-bit registers.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- s_axis_tvalid_i  in  1  input stream valid
- s_axis_tready_o  out  1  input stream ready
- s_axis_tlast_i  in  1  input end of packet
- s_axis_tdata_i  in  AXIS_DIN_W  input data
- m_axis_tvalid_o  out  1  output stream valid
- m_axis_tready_i  in  1  output stream ready
- m_axis_tlast_o  out  1  output end of packet
- m_axis_tdata_o  out  AXIS_DIN_W  output data
- drop_cnt_o  out  CNT_W  packets dropped (saturating)
- fwd_cnt_o  out  CNT_W  packets forwarded (saturating)

Behaviour:
- Reset values: s_axis_tready_o=1, m_axis_tvalid_o=0, m_axis_tlast_o=0, m_axis_tdata_o=0, all regs=0, both counters=0, state=RECV, all buffer pointers=0.
- Reset has priority and aborts any packet in progress on either side. The partial packet is neither forwarded nor counted.
- Handshake rules:
  - A beat transfers when valid && ready.
  - m_axis_tdata_o and m_axis_tlast_o are held stable while tvalid=1 and tready=0.
  - tvalid is never withdrawn without a handshake.
- State RECV, tready=1:
  - Each beat is written to buf[wr_ptr] and wr_ptr increments.
  - Beats arriving at wr_ptr==BUF_S set an oversize flag and are discarded; the pointer does not wrap.
  - On the tlast handshake: len=wr_ptr+1 (capped at BUF_S), wr_ptr resets, and the block moves to DECODE.
- State DECODE, one cycle, tready=0. Checks are applied in this order:
  - oversize or len<2 -> drop_cnt++, go to RECV.
  - buf[0]==ID -> go to EXEC.
  - buf[0]==8'hFF -> go to FWD with exec_pending=1.
  - Otherwise -> go to FWD.
- State FWD:
  - Streams buf[0..len-1]; m_axis_tvalid_o rises the cycle after DECODE. Latency from input tlast handshake to first output valid is 2 cycles.
  - tlast is asserted on beat len-1.
  - On the final handshake: fwd_cnt++; go to EXEC if exec_pending, else RECV.
- State EXEC, one cycle, tready=0. Commands are decoded on buf[1]:
  - CMD_WR=8'h01: regs[i]=buf[2+i] for i < min(len-2, REG_N); extra payload is ignored; go to RECV.
  - CMD_CLR=8'h21: all regs=0; go to RECV.
  - CMD_SEND=8'h11: go to REPLY.
  - Unknown command: drop_cnt++, go to RECV. A broadcast packet is still forwarded before this point.
- State REPLY:
  - Emits REG_N+3 beats: 8'hAA, ID, regs[0..REG_N-1], then XOR of all preceding beats.
  - tlast is asserted on the last beat; on its handshake go to RECV.
- Register contents sampled for a reply are those present at EXEC entry.
- Counters saturate at all-ones.
- tready is only high in RECV. Input is held off during DECODE, FWD, EXEC and REPLY.
- Widths: beat-0 and beat-1 comparisons use bits [7:0] only. Upper bits of beats 0/1 are forwarded unchanged. Reply beat 0 and beat 1 are zero-extended.

Decomposition:
- Package eu_ring_pkg holds: CMD_WR, CMD_SEND, CMD_CLR, BC_ID, REPLY_HDR (8'hAA), the state enum (RECV, DECODE, FWD, EXEC, REPLY), and the function reply_len(REG_N).
- Sub-module eu_pkt_buf holds the buffer RAM, write pointer, oversize flag, length capture and read port.
- The FSM, register file and reply generation stay in eu_ring_node.

Test Plan:
- Foreign packet {02,01,33,44} with tready=1 -> identical 4 beats out, tlast on 44, first valid 2 cycles after input tlast, fwd_cnt=1.
- Self packet {01,01,AA,BB,CC} then {01,11} -> reply AA,01,AA,BB,CC,00x13,XOR checksum; tlast on checksum, fwd_cnt=0.
- Broadcast packet {FF,21} after a write -> packet forwarded unchanged, then regs all 0; a subsequent {01,11} reply shows zero registers.
- Oversize packet of BUF_S+5 beats and runt packet {01} -> no output, drop_cnt=2, tready never deasserted mid-packet.
- Random m_axis_tready_i toggling during a REPLY -> data and tlast stable while stalled; beat order and checksum correct.
- reset_i pulsed mid-FWD -> next cycle tvalid=0, tready=1, counters=0; the following packet is handled normally.
